// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operand stage:
//   - default operand / register-address widths
//   - operand-mode encodings (in_src_sel)
//   - ALU opcode encodings carried through on aluop
//   - helpers telling which register sources an operand mode reads
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // Operand modes
  localparam logic [1:0] SRC_RR    = 2'd0;  // x=rs, y=rt
  localparam logic [1:0] SRC_RI_S  = 2'd1;  // x=rs, y=sign-extended imm
  localparam logic [1:0] SRC_RI_Z  = 2'd2;  // x=rs, y=zero-extended imm
  localparam logic [1:0] SRC_SHAMT = 2'd3;  // x=rt, y=zero-extended shamt

  // ALU opcodes (prefixed: AND/OR/XOR are reserved words)
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRA  = 4'd1,
    ALU_SRL  = 4'd2,
    ALU_MUL  = 4'd3,
    ALU_DIV  = 4'd4,
    ALU_ADD  = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_AND  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_XOR  = 4'd9,
    ALU_NOR  = 4'd10,
    ALU_SLT  = 4'd11,
    ALU_SLTU = 4'd12
  } alu_op_e;

  function automatic logic src_uses_rs(input logic [1:0] mode);
    return (mode != SRC_SHAMT);
  endfunction

  function automatic logic src_uses_rt(input logic [1:0] mode);
    return (mode == SRC_RR) || (mode == SRC_SHAMT);
  endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// ---------------------------------------------------------------------------
// alu_fwd_mux
// Bypass selector for one register source operand. Picks the EX result if
// the instruction in EX writes this register, else the MEM result if the
// instruction in MEM writes it, else the register-file value. Register 0 is
// hardwired to zero and never matches. The hit flags are also used by the
// parent for hazard detection.
// Ports:
//   used                      source is actually read by the current mode
//   src_addr, reg_val         source register address / register-file value
//   ex_wr_en/ex_dst_addr/ex_result     instruction in EX
//   mem_wr_en/mem_dst_addr/mem_result  instruction in MEM
//   fwd_val                   selected operand value
//   ex_hit, mem_hit           source matches EX / MEM destination
// ---------------------------------------------------------------------------
module alu_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              used,
  input  logic [REG_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] reg_val,
  input  logic              ex_wr_en,
  input  logic [REG_AW-1:0] ex_dst_addr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_dst_addr,
  input  logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] fwd_val,
  output logic              ex_hit,
  output logic              mem_hit
);

  logic src_nz;

  always_comb begin
    src_nz  = (src_addr != '0);
    ex_hit  = used && src_nz && ex_wr_en  && (ex_dst_addr  == src_addr);
    mem_hit = used && src_nz && mem_wr_en && (mem_dst_addr == src_addr);
    // EX holds the younger write, so it wins over MEM
    if (ex_hit)       fwd_val = ex_result;
    else if (mem_hit) fwd_val = mem_result;
    else              fwd_val = reg_val;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// Builds the two ALU operands from a decoded instruction bundle, resolving
// data hazards against the instructions in EX and MEM, and registers them
// behind a valid/ready handshake (one-cycle latency).
//
// Build option: define ALU_FWD_EN to enable EX/MEM bypassing; only a
// load in EX then stalls. Without it, register values are used directly and
// any pending EX/MEM write to a used source stalls the bundle.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid / in_ready             decode bundle handshake
//   in_rs_val, in_rt_val            register-file read values
//   in_rs_addr, in_rt_addr          source addresses
//   in_dst_addr, in_wr_en           destination / write-back enable
//   in_imm, in_shamt, in_aluop      immediate, shift amount, opcode
//   in_src_sel                      operand mode (SRC_*)
//   ex_*, mem_*                     instructions currently in EX / MEM
//   flush                           drop held and incoming bundles
//   out_valid / out_ready           ALU-side handshake
//   x, y, aluop, out_dst_addr, out_wr_en   registered bundle to the ALU
//   stall_cnt                       saturating count of hazard stall cycles
// ---------------------------------------------------------------------------
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int REG_AW = alu_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  input  logic [REG_AW-1:0] in_rs_addr,
  input  logic [REG_AW-1:0] in_rt_addr,
  input  logic [REG_AW-1:0] in_dst_addr,
  input  logic [15:0]       in_imm,
  input  logic [4:0]        in_shamt,
  input  logic [3:0]        in_aluop,
  input  logic [1:0]        in_src_sel,
  input  logic              in_wr_en,
  input  logic              ex_wr_en,
  input  logic [REG_AW-1:0] ex_dst_addr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_is_load,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_dst_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic [3:0]        aluop,
  output logic [REG_AW-1:0] out_dst_addr,
  output logic              out_wr_en,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              rs_used, rt_used;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  logic              rs_ex_hit, rs_mem_hit, rt_ex_hit, rt_mem_hit;
  logic [DATA_W-1:0] rs_op, rt_op;
  logic              hazard, accept;

  logic              out_valid_d, out_valid_q;
  logic [DATA_W-1:0] x_d, x_q, y_d, y_q;
  logic [3:0]        aluop_d, aluop_q;
  logic [REG_AW-1:0] dst_d, dst_q;
  logic              wr_en_d, wr_en_q;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

  assign rs_used = src_uses_rs(in_src_sel);
  assign rt_used = src_uses_rt(in_src_sel);

  alu_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rs_fwd (
    .used         (rs_used),
    .src_addr     (in_rs_addr),
    .reg_val      (in_rs_val),
    .ex_wr_en     (ex_wr_en),
    .ex_dst_addr  (ex_dst_addr),
    .ex_result    (ex_result),
    .mem_wr_en    (mem_wr_en),
    .mem_dst_addr (mem_dst_addr),
    .mem_result   (mem_result),
    .fwd_val      (rs_fwd),
    .ex_hit       (rs_ex_hit),
    .mem_hit      (rs_mem_hit)
  );

  alu_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rt_fwd (
    .used         (rt_used),
    .src_addr     (in_rt_addr),
    .reg_val      (in_rt_val),
    .ex_wr_en     (ex_wr_en),
    .ex_dst_addr  (ex_dst_addr),
    .ex_result    (ex_result),
    .mem_wr_en    (mem_wr_en),
    .mem_dst_addr (mem_dst_addr),
    .mem_result   (mem_result),
    .fwd_val      (rt_fwd),
    .ex_hit       (rt_ex_hit),
    .mem_hit      (rt_mem_hit)
  );

`ifdef ALU_FWD_EN
  // Bypass covers everything except a load still in EX (data not ready yet)
  assign rs_op  = rs_fwd;
  assign rt_op  = rt_fwd;
  assign hazard = ex_is_load && (rs_ex_hit || rt_ex_hit);
`else
  // No bypass: wait until every pending write to a used source has retired
  logic unused_nofwd;
  assign rs_op  = in_rs_val;
  assign rt_op  = in_rt_val;
  assign hazard = rs_ex_hit || rs_mem_hit || rt_ex_hit || rt_mem_hit;
  assign unused_nofwd = ^{rs_fwd, rt_fwd, ex_is_load};
`endif

  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // operand mux
    x_d = rs_op;
    y_d = rt_op;
    unique case (in_src_sel)
      SRC_RR:    begin x_d = rs_op; y_d = rt_op; end
      SRC_RI_S:  begin x_d = rs_op; y_d = {{(DATA_W-16){in_imm[15]}}, in_imm}; end
      SRC_RI_Z:  begin x_d = rs_op; y_d = {{(DATA_W-16){1'b0}}, in_imm}; end
      SRC_SHAMT: begin x_d = rt_op; y_d = {{(DATA_W-5){1'b0}}, in_shamt}; end
      default:   begin x_d = rs_op; y_d = rt_op; end
    endcase
    aluop_d = in_aluop;
    dst_d   = in_dst_addr;
    wr_en_d = in_wr_en;

    // flush dominates; otherwise a new transfer refills, a consumed one drains
    if (flush)          out_valid_d = 1'b0;
    else if (accept)    out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    else                out_valid_d = out_valid_q;

    stall_cnt_d = stall_cnt_q;
    if (in_valid && hazard && !flush && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // ---- stage boundary: operand bundle register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      aluop_q     <= '0;
      dst_q       <= '0;
      wr_en_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
      if (accept) begin
        x_q     <= x_d;
        y_q     <= y_d;
        aluop_q <= aluop_d;
        dst_q   <= dst_d;
        wr_en_q <= wr_en_d;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign x            = x_q;
  assign y            = y_q;
  assign aluop        = aluop_q;
  assign out_dst_addr = dst_q;
  assign out_wr_en    = wr_en_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
// Scoreboard bench: an expected bundle is queued whenever the bench drives a
// bundle it expects to be accepted, and checked when the DUT presents it
// with out_ready high. Directed checks cover handshake, stalls and reset.
// Expectations adapt to the ALU_FWD_EN build option.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 3;

  logic          clk, rst_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_rs_val, in_rt_val;
  logic [AW-1:0] in_rs_addr, in_rt_addr, in_dst_addr;
  logic [15:0]   in_imm;
  logic [4:0]    in_shamt;
  logic [3:0]    in_aluop;
  logic [1:0]    in_src_sel;
  logic          in_wr_en;
  logic          ex_wr_en, ex_is_load, mem_wr_en;
  logic [AW-1:0] ex_dst_addr, mem_dst_addr;
  logic [DW-1:0] ex_result, mem_result;
  logic          flush, out_valid, out_ready;
  logic [DW-1:0] x, y;
  logic [3:0]    aluop;
  logic [AW-1:0] out_dst_addr;
  logic          out_wr_en;
  logic [CW-1:0] stall_cnt;

  alu_operand_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_dst_addr(in_dst_addr),
    .in_imm(in_imm), .in_shamt(in_shamt), .in_aluop(in_aluop),
    .in_src_sel(in_src_sel), .in_wr_en(in_wr_en),
    .ex_wr_en(ex_wr_en), .ex_dst_addr(ex_dst_addr), .ex_result(ex_result),
    .ex_is_load(ex_is_load),
    .mem_wr_en(mem_wr_en), .mem_dst_addr(mem_dst_addr), .mem_result(mem_result),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .y(y), .aluop(aluop), .out_dst_addr(out_dst_addr),
    .out_wr_en(out_wr_en), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [3:0]    op;
    logic [AW-1:0] dst;
    logic          wr;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_cur;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_stall = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, req);
    end
  endtask

  // Output monitor: a presented bundle is consumed at the next edge
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_x",   x,            e.x);
        chk("sb_y",   y,            e.y);
        chk("sb_op",  aluop,        e.op);
        chk("sb_dst", out_dst_addr, e.dst);
        chk("sb_wr",  out_wr_en,    e.wr);
      end
    end
  end

  task automatic idle();
    in_valid = 0; in_rs_val = 0; in_rt_val = 0; in_rs_addr = 0; in_rt_addr = 0;
    in_dst_addr = 0; in_imm = 0; in_shamt = 0; in_aluop = 0; in_src_sel = 0;
    in_wr_en = 0; ex_wr_en = 0; ex_dst_addr = 0; ex_result = 0; ex_is_load = 0;
    mem_wr_en = 0; mem_dst_addr = 0; mem_result = 0; flush = 0;
  endtask

  task automatic bundle(input logic [1:0] sel, input logic [AW-1:0] rs_a,
                        input logic [DW-1:0] rs_v, input logic [AW-1:0] rt_a,
                        input logic [DW-1:0] rt_v, input logic [15:0] imm,
                        input logic [4:0] sh, input logic [3:0] op,
                        input logic [AW-1:0] dst);
    in_valid = 1; in_src_sel = sel; in_rs_addr = rs_a; in_rs_val = rs_v;
    in_rt_addr = rt_a; in_rt_val = rt_v; in_imm = imm; in_shamt = sh;
    in_aluop = op; in_dst_addr = dst; in_wr_en = 1;
  endtask

  task automatic set_exp(input logic [DW-1:0] ex, input logic [DW-1:0] ey);
    exp_cur.x = ex; exp_cur.y = ey; exp_cur.op = in_aluop;
    exp_cur.dst = in_dst_addr; exp_cur.wr = in_wr_en;
  endtask

  // One clock: check in_ready before the edge, queue the bundle if it transfers
  task automatic step(input logic exp_rdy);
    @(negedge clk); #1;
    chk("in_ready", in_ready, exp_rdy);
    if (in_valid && exp_rdy) sb_q.push_back(exp_cur);
    @(posedge clk); #2;
  endtask

  initial begin
    idle();
    out_ready = 1;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_x",     x,         0);
    chk("rst_y",     y,         0);
    chk("rst_stall", stall_cnt, 0);
    rst_n = 1;
    @(posedge clk); #2;

    // mode 1: sign-extended immediate
    bundle(SRC_RI_S, 5'd3, 32'h10, 5'd6, 32'h77, 16'hFFFE, 5'd0, ALU_ADD, 5'd4);
    set_exp(32'h10, 32'hFFFF_FFFE);
    step(1);
    chk("A_valid", out_valid, 1);
    chk("A_y", y, 32'hFFFF_FFFE);
    idle();
    step(1);
    chk("A_drain", out_valid, 0);

    // $0 never forwards nor stalls
    bundle(SRC_RR, 5'd1, 32'h7, 5'd0, 32'h0, 16'h0, 5'd0, ALU_SUB, 5'd2);
    ex_wr_en = 1; ex_dst_addr = 5'd0; ex_result = 32'h1234;
    set_exp(32'h7, 32'h0);
    step(1);
    idle();
    step(1);

    // EX and MEM both write $5
    bundle(SRC_RR, 5'd5, 32'h55, 5'd6, 32'h66, 16'h0, 5'd0, ALU_AND, 5'd9);
    ex_wr_en = 1; ex_dst_addr = 5'd5; ex_result = 32'hAAAA;
    mem_wr_en = 1; mem_dst_addr = 5'd5; mem_result = 32'hBBBB;
`ifdef ALU_FWD_EN
    set_exp(32'hAAAA, 32'h66);
    step(1);
`else
    step(0);
    step(0);
    ex_wr_en = 0;
    step(0);
    exp_stall += 3;
    mem_wr_en = 0;
    set_exp(32'h55, 32'h66);
    step(1);
`endif
    chk("C_stall", stall_cnt, exp_stall);
    idle();
    step(1);

    // mode 3: rt is a load in EX -> one stall, then accept
    bundle(SRC_SHAMT, 5'd9, 32'h5, 5'd7, 32'h99, 16'h0, 5'd4, ALU_SLL, 5'd8);
    ex_wr_en = 1; ex_dst_addr = 5'd7; ex_is_load = 1; ex_result = 32'hDEAD;
    step(0);
    exp_stall += 1;
    chk("D_stall", stall_cnt, exp_stall);
    ex_wr_en = 0; ex_is_load = 0;
    set_exp(32'h99, 32'h4);
    step(1);
    idle();
    step(1);

    // mode 3 ignores rs: pending writes to rs must not stall or forward
    bundle(SRC_SHAMT, 5'd9, 32'h5, 5'd7, 32'h99, 16'h0, 5'd31, ALU_SRL, 5'd8);
    ex_wr_en = 1; ex_dst_addr = 5'd9; ex_is_load = 1; ex_result = 32'hDEAD;
    mem_wr_en = 1; mem_dst_addr = 5'd9; mem_result = 32'hBEEF;
    set_exp(32'h99, 32'd31);
    step(1);
    idle();
    step(1);

    // mode 2: zero-extended immediate
    bundle(SRC_RI_Z, 5'd2, 32'h100, 5'd0, 32'h0, 16'h8001, 5'd0, ALU_OR, 5'd3);
    set_exp(32'h100, 32'h0000_8001);
    step(1);
    idle();
    step(1);

    // backpressure then flush
    out_ready = 0;
    bundle(SRC_RR, 5'd2, 32'h11, 5'd3, 32'h22, 16'h0, 5'd0, ALU_OR, 5'd10);
    set_exp(32'h11, 32'h22);
    step(1);
    bundle(SRC_RR, 5'd4, 32'h44, 5'd5, 32'h55, 16'h0, 5'd0, ALU_XOR, 5'd11);
    set_exp(32'h44, 32'h55);
    for (int i = 0; i < 3; i++) begin
      step(0);
      chk("G_hold_valid", out_valid, 1);
      chk("G_hold_x", x, 32'h11);
      chk("G_hold_y", y, 32'h22);
      chk("G_hold_dst", out_dst_addr, 5'd10);
    end
    flush = 1;
    step(0);
    chk("G_flush_valid", out_valid, 0);
    chk("G_sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    idle();
    out_ready = 1;
    step(1);

    // stall counter: flush suppresses counting, then saturation
    bundle(SRC_RR, 5'd5, 32'h1, 5'd6, 32'h2, 16'h0, 5'd0, ALU_ADD, 5'd1);
    ex_wr_en = 1; ex_dst_addr = 5'd5; ex_is_load = 1;
    flush = 1;
    step(0);
    chk("H_flush_nocount", stall_cnt, exp_stall);
    flush = 0;
    for (int i = 0; i < 6; i++) step(0);
    chk("H_saturate", stall_cnt, 3'd7);
    idle();
    step(1);

    // asynchronous reset with a held bundle
    out_ready = 0;
    bundle(SRC_RR, 5'd1, 32'hCAFE, 5'd2, 32'hBEEF, 16'h0, 5'd0, ALU_XOR, 5'd3);
    set_exp(32'hCAFE, 32'hBEEF);
    step(1);
    chk("I_valid", out_valid, 1);
    #1 rst_n = 0;
    #1;
    chk("I_rst_valid", out_valid, 0);
    chk("I_rst_x", x, 0);
    chk("I_rst_y", y, 0);
    chk("I_rst_op", aluop, 0);
    chk("I_rst_dst", out_dst_addr, 0);
    chk("I_rst_wr", out_wr_en, 0);
    chk("I_rst_stall", stall_cnt, 0);
    sb_q.delete();
    idle();
    out_ready = 1;
    @(posedge clk); #2;
    rst_n = 1;
    step(1);
    chk("I_after_valid", out_valid, 0);

    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
